// File: rtl/data_mem_mp_pkg.sv
// rtl/data_mem_mp_pkg.sv - shared types, size encoding and lane helper for data_mem_mp
package data_mem_mp_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Reserved size code 3 falls into the word case.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_ld_ext.sv
// rtl/dmem_ld_ext.sv - load byte extraction with sign/zero extension
module dmem_ld_ext
  import data_mem_mp_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: data_o = {{16{~uns_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_mem_mp.sv
// rtl/data_mem_mp.sv - multi-port byte-addressed data memory with clear sweep
// Optional misaligned-access rejection: DMEM_MISALIGN_CHECK_EN.
module data_mem_mp
  import data_mem_mp_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int DEPTH_BYTES = 64,
  parameter int READ_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_valid,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic [NUM_PORTS-1:0]       req_write,
  input  logic [NUM_PORTS-1:0][1:0]  req_size,
  input  logic [NUM_PORTS-1:0]       req_unsigned,
  input  logic [NUM_PORTS-1:0][31:0] req_addr,
  input  logic [NUM_PORTS-1:0][31:0] req_wdata,
  output logic [NUM_PORTS-1:0]       resp_valid,
  output logic [NUM_PORTS-1:0]       resp_write,
  output logic [NUM_PORTS-1:0][31:0] resp_rdata,
  output logic [NUM_PORTS-1:0]       resp_err,
  output logic                       init_done
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = AW - 2;

  state_e                     state_q, state_d;
  logic [CW-1:0]              init_cnt_q, init_cnt_d;
  logic                       run;
  logic [7:0]                 mem_q [DEPTH_BYTES];
  logic [7:0]                 mem_d [DEPTH_BYTES];

  req_t  [NUM_PORTS-1:0]      req;
  logic  [NUM_PORTS-1:0]      accept, misalign, do_store;
  logic  [NUM_PORTS-1:0][3:0] lane_en;
  logic  [AW-1:0]             byte_idx [NUM_PORTS][4];
  logic  [NUM_PORTS-1:0][31:0] raw_word, ext_data;
  resp_t [NUM_PORTS-1:0]      s1_d, s1_q, out_rsp;
  logic                       unused_addr_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    run        = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CW'(1);
        if (init_cnt_q == CW'(WORDS - 1)) state_d = ST_RUN;
      end
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = {NUM_PORTS{run}};
  assign init_done = run;

  // Byte lanes wrap modulo the memory size, independent of alignment.
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p] = '{write: req_write[p], size: req_size[p], uns: req_unsigned[p],
                 addr: req_addr[p], wdata: req_wdata[p]};
      accept[p]  = req_valid[p] & run;
      lane_en[p] = size_mask(req[p].size);
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign[p] = ((req[p].size == SZ_HALF) && req[p].addr[0]) ||
                    (req[p].size[1] && (req[p].addr[1:0] != 2'b00));
`else
      misalign[p] = 1'b0;
`endif
      do_store[p] = accept[p] & req[p].write & ~misalign[p];
      for (int k = 0; k < 4; k++) begin
        byte_idx[p][k]        = req[p].addr[AW-1:0] + AW'(k);
        raw_word[p][8*k +: 8] = mem_q[byte_idx[p][k]];
      end
      unused_addr_hi = unused_addr_hi ^ (^req[p].addr[31:AW]);
    end
  end

  // Ascending port order so the highest-numbered port owns a contested byte.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_INIT) begin
      for (int k = 0; k < 4; k++) mem_d[{init_cnt_q, 2'(k)}] = 8'h00;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int k = 0; k < 4; k++) begin
          if (do_store[p] && lane_en[p][k]) mem_d[byte_idx[p][k]] = req[p].wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ext
    dmem_ld_ext u_ext (
      .raw_i  (raw_word[p]),
      .size_i (req_size[p]),
      .uns_i  (req_unsigned[p]),
      .data_o (ext_data[p])
    );
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      s1_d[p].valid = accept[p];
      s1_d[p].write = accept[p] & req[p].write;
      s1_d[p].err   = accept[p] & misalign[p];
      s1_d[p].rdata = (accept[p] && !req[p].write && !misalign[p]) ? ext_data[p] : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  if (READ_LAT == 2) begin : g_lat2
    resp_t [NUM_PORTS-1:0] s2_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) s2_q <= '0;
      else       s2_q <= s1_q;
    end
    assign out_rsp = s2_q;
  end else begin : g_lat1
    assign out_rsp = s1_q;
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_valid[p] = out_rsp[p].valid;
      resp_write[p] = out_rsp[p].write;
      resp_rdata[p] = out_rsp[p].rdata;
      resp_err[p]   = out_rsp[p].err;
    end
  end

endmodule

// File: tb/tb_data_mem_mp.sv
// tb/tb_data_mem_mp.sv - bench for data_mem_mp at read latency 1 and 2 against a byte-array model
module tb_data_mem_mp;

  localparam int NP    = 3;
  localparam int DEPTH = 64;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NP-1:0]       rv = '0, rw = '0, ru = '0;
  logic [NP-1:0][1:0]  rs = '0;
  logic [NP-1:0][31:0] ra = '0, rwd = '0;
  logic [NP-1:0]       rdy1, vld1, wr1, err1, rdy2, vld2, wr2, err2;
  logic [NP-1:0][31:0] rd1, rd2;
  logic                done1, done2;

  always #5 clk = ~clk;

  data_mem_mp #(.NUM_PORTS(NP), .DEPTH_BYTES(DEPTH), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(rst), .req_valid(rv), .req_ready(rdy1), .req_write(rw),
    .req_size(rs), .req_unsigned(ru), .req_addr(ra), .req_wdata(rwd),
    .resp_valid(vld1), .resp_write(wr1), .resp_rdata(rd1), .resp_err(err1),
    .init_done(done1));

  data_mem_mp #(.NUM_PORTS(NP), .DEPTH_BYTES(DEPTH), .READ_LAT(2)) dut2 (
    .clk(clk), .reset(rst), .req_valid(rv), .req_ready(rdy2), .req_write(rw),
    .req_size(rs), .req_unsigned(ru), .req_addr(ra), .req_wdata(rwd),
    .resp_valid(vld2), .resp_write(wr2), .resp_rdata(rd2), .resp_err(err2),
    .init_done(done2));

  logic [7:0]  mem_m [DEPTH];
  logic [34:0] exp1 [NP];
  logic [34:0] exp2 [NP];
  bit          ready_m = 1'b0;
  int          init_edges = 0;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return CHECK_EN && ((int'(a[5:0]) % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] mload(input int a, input int n, input bit uns);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(mem_m[(a + k) % DEPTH]) << (8 * k);
    if (!uns && n < 4 && v[8*n-1]) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic setp(input int p, input bit v, input bit w, input logic [1:0] s,
                      input bit u, input logic [31:0] a, input logic [31:0] d);
    rv[p] = v; rw[p] = w; rs[p] = s; ru[p] = u; ra[p] = a; rwd[p] = d;
  endtask

  task automatic idle();
    rv = '0;
  endtask

  // One clock: predict responses from pre-edge memory, then apply stores in port order.
  task automatic step();
    logic [34:0] e [NP];
    for (int p = 0; p < NP; p++) begin
      bit m;
      m = misal(rs[p], ra[p]);
      e[p] = '0;
      if (rv[p] && ready_m && !rst) begin
        if (rw[p]) e[p] = {1'b1, 1'b1, m, 32'h0};
        else       e[p] = {1'b1, 1'b0, m, m ? 32'h0 : mload(int'(ra[p][5:0]), nbytes(rs[p]), ru[p])};
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (rv[p] && ready_m && !rst && rw[p] && !misal(rs[p], ra[p])) begin
        for (int k = 0; k < nbytes(rs[p]); k++)
          mem_m[(int'(ra[p][5:0]) + k) % DEPTH] = rwd[p][8*k +: 8];
      end
    end
    @(posedge clk);
    if (rst) begin
      ready_m = 1'b0;
      init_edges = 0;
    end else if (!ready_m) begin
      init_edges++;
      if (init_edges == DEPTH / 4) ready_m = 1'b1;
    end
    #1;
    for (int p = 0; p < NP; p++) begin
      exp2[p] = exp1[p];
      exp1[p] = e[p];
    end
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("lat1_resp_p%0d", p), {29'b0, vld1[p], wr1[p], err1[p], rd1[p]}, {29'b0, exp1[p]});
      chk($sformatf("lat2_resp_p%0d", p), {29'b0, vld2[p], wr2[p], err2[p], rd2[p]}, {29'b0, exp2[p]});
    end
    chk("lat1_ready", 64'(rdy1), 64'({NP{ready_m}}));
    chk("lat2_ready", 64'(rdy2), 64'({NP{ready_m}}));
    chk("lat1_init_done", 64'(done1), 64'(ready_m));
    chk("lat2_init_done", 64'(done2), 64'(ready_m));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int p = 0; p < NP; p++) begin
      exp1[p] = '0;
      exp2[p] = '0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ready_m = 1'b0;
    init_edges = 0;
    chk("rst_valid1", 64'(vld1), 64'h0);
    chk("rst_valid2", 64'(vld2), 64'h0);
    chk("rst_outs1", {31'b0, wr1, err1, rdy1, done1, rd1[0] | rd1[1] | rd1[2]}, 64'h0);
    chk("rst_outs2", {31'b0, wr2, err2, rdy2, done2, rd2[0] | rd2[1] | rd2[2]}, 64'h0);
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    rst = 1'b0;
    while (!done1 && cnt < 100) begin
      step();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'd16);
  endtask

  initial begin
    #2;
    do_reset();
    step();
    step();
    wait_init("init_cycles");

    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++)
        setp(p, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 255), 32'h0);
      step();
      for (int p = 0; p < NP; p++) chk("load_after_init", rd1[p], 64'h0);
    end

    idle(); setp(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h8081_8283); step();
    idle(); setp(1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h4, 32'h0); setp(2, 1'b1, 1'b0, 2'd1, 1'b1, 32'h6, 32'h0); step();
    chk("byte_signed_0x4", rd1[1], 64'hFFFF_FF83);
    chk("half_unsigned_0x6", rd1[2], 64'h0000_8081);

    idle(); setp(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h1111_1111); setp(2, 1'b1, 1'b1, 2'd0, 1'b0, 32'h8, 32'h0000_00AA); step();
    idle(); setp(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0); step();
    chk("overlap_store_0x8", rd1[1], 64'h1111_11AA);

    idle(); setp(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF); setp(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0); step();
    chk("rbw_old_0x10", rd1[1], 64'h0);
    idle(); setp(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0); step();
    chk("rbw_new_0x10", rd1[1], 64'hDEAD_BEEF);

    idle(); setp(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h3E, 32'h0403_0201); step();
    chk("wrap_store_err", 64'(err1[0]), 64'(CHECK_EN));
    idle(); setp(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h3E, 32'h0); setp(1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h3F, 32'h0);
    setp(2, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0); step();
    chk("wrap_byte_0x3e", rd1[0], CHECK_EN ? 64'h0 : 64'h1);
    chk("wrap_byte_0x3f", rd1[1], CHECK_EN ? 64'h0 : 64'h2);
    chk("wrap_byte_0x00", rd1[2], CHECK_EN ? 64'h0 : 64'h3);
    idle(); setp(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h1, 32'h0); step();
    chk("wrap_byte_0x01", rd1[0], CHECK_EN ? 64'h0 : 64'h4);

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++)
        setp(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 255), $urandom);
      step();
    end

    for (int p = 0; p < NP; p++) setp(p, 1'b1, 1'b0, 2'd2, 1'b0, $urandom_range(0, 63), 32'h0);
    step();
    do_reset();
    step();
    wait_init("reinit_cycles");
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < NP; p++)
        setp(p, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 255), 32'h0);
      step();
      for (int p = 0; p < NP; p++) chk("load_after_reinit", rd1[p], 64'h0);
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/data_mem_mp.md
DATA_MEM_MP -- requirements
Module: data_mem_mp

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of independent request/response ports; legal 1..8.
REQ-002 Parameter DEPTH_BYTES, default 64, byte capacity; power of two, multiple of 4, ≥8.
REQ-003 Parameter READ_LAT, default 1, cycles from accepted request to response; legal 1 or 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  [NUM_PORTS]  request present on port p.
REQ-007 req_ready  out  [NUM_PORTS]  port p accepts request this cycle.
REQ-008 req_write  in  [NUM_PORTS]  1 = store, 0 = load.
REQ-009 req_size  in  [NUM_PORTS][2]  0 = byte, 1 = half, 2 = word; 3 is reserved, treated as word.
REQ-010 req_unsigned  in  [NUM_PORTS]  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  [NUM_PORTS][32]  byte address.
REQ-012 req_wdata  in  [NUM_PORTS][32]  store data, low bytes used per size.
REQ-013 resp_valid  out  [NUM_PORTS]  response for port p.
REQ-014 resp_write  out  [NUM_PORTS]  echoes req_write of the responded request.
REQ-015 resp_rdata  out  [NUM_PORTS][32]  extended load data; 0 for stores.
REQ-016 resp_err  out  [NUM_PORTS]  misaligned-access flag (see Configuration).
REQ-017 init_done  out  1  memory clear sweep complete.

Function
REQ-018 FSM states INIT, RUN; INIT clears 4 bytes per cycle at word index init_cnt, init_cnt increments 0..DEPTH_BYTES/4-1, then RUN next cycle.
REQ-019 In INIT req_ready = 0 and init_done = 0; in RUN req_ready = all ones and init_done = 1.
REQ-020 Request accepted when req_valid & req_ready; no other stall source.
REQ-021 Byte address = req_addr mod DEPTH_BYTES; bytes addr+1..addr+3 wrap mod DEPTH_BYTES.
REQ-022 Byte lanes little-endian: byte k of data at address addr+k.
REQ-023 Store writes 1/2/4 bytes per size at the accepting edge.
REQ-024 Same-cycle stores to overlapping bytes: applied in ascending port order, highest port index wins per byte.
REQ-025 Load reads memory state before same-cycle stores (read-before-write), all ports.
REQ-026 Load data captured at acceptance, delivered with resp_valid exactly READ_LAT cycles later; READ_LAT=2 adds one pipeline register.
REQ-027 Store also produces resp_valid READ_LAT cycles later, resp_rdata = 0.
REQ-028 Pipeline fully pipelined: one request per port per cycle, no bubbles.
REQ-029 resp_valid = 0 whenever no accepted request at the matching stage.

Reset
REQ-030 reset assertion immediately: state INIT, init_cnt 0, all pipeline valids 0, resp_valid/resp_write/resp_rdata/resp_err 0, init_done 0, req_ready 0.
REQ-031 Reset mid-operation drops in-flight responses; memory contents undefined until the sweep completes.
REQ-032 Sweep starts first edge after reset deasserts; init_done rises after DEPTH_BYTES/4 cycles.

Configuration
REQ-033 Macro DMEM_MISALIGN_CHECK_EN defined: half at odd address or word at address[1:0]≠0 is not performed (no store, rdata 0), resp_err = 1 at response time.
REQ-034 Macro undefined: misaligned accesses performed with byte wrap per REQ-021, resp_err tied 0.

Structure
REQ-035 Shared package holds request/response structs, size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum.
REQ-036 One sub-module dmem_ld_ext: size/unsigned-driven byte extraction and sign/zero extension, instantiated per port.

Verification
REQ-037 Reset, count cycles -> init_done high after exactly 16 cycles (DEPTH 64); all loads then return 0.
REQ-038 Port0 store word 0x8081_8283 at 0x4, next cycle port1 load byte signed 0x4 -> 0xFFFF_FF83; unsigned half 0x6 -> 0x0000_8081.
REQ-039 Same cycle port0 store word 0x1111_1111 and port2 store byte 0xAA at 0x8 -> later word load 0x8 returns 0x1111_11AA.
REQ-040 Same cycle port0 store 0xDEAD_BEEF at 0x10 and port1 load 0x10 -> port1 gets old value; subsequent load gets 0xDEAD_BEEF.
REQ-041 Store word 0x0403_0201 at 0x3E: macro on -> resp_err 1, memory unchanged; off -> bytes at 0x3E,0x3F,0x00,0x01 = 01,02,03,04.
REQ-042 Reset asserted with loads in flight, READ_LAT=2 -> no resp_valid emitted; req_ready low until sweep completes.
